// File: rtl/clk_switch_ctrl.sv
// Clock-switch sequencer driving the select input of a two-clock glitch-free mux.
// Optional macro CLKSW_SW_LOCK_EN adds a sw_lock input that blocks software requests.
module clk_switch_ctrl #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hw_req_valid,
    input  logic hw_req_sel,
    output logic hw_req_ready,
    input  logic sw_req_valid,
    input  logic sw_req_sel,
    output logic sw_req_ready,
`ifdef CLKSW_SW_LOCK_EN
    input  logic sw_lock,
`endif
    input  logic clk0_alive,
    input  logic clk1_alive,
    output logic select,
    output logic busy,
    output logic done,
    output logic err
);

    // state    | meaning
    // IDLE     | waiting for a request; readies may assert
    // DONE_NOP | requested source already selected; done pulse, no hold
    // CHECK    | waiting for both clocks alive before moving select
    // SETTLE   | select moved; waiting out the mux handover
    // HOLD     | minimum dwell after done; no requests accepted
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DONE_NOP = 3'd1,
        S_CHECK    = 3'd2,
        S_SETTLE   = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TC_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
    // The done cycle itself is not part of the dwell, so HOLD runs one count longer.
    localparam logic [CNT_W-1:0] TC_HOLD    = CNT_W'(HOLD_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             select_q, select_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       alive_meta_q, alive_s_q;
    logic             sw_locked;
    logic             hw_accept, sw_accept, req_sel;

`ifdef CLKSW_SW_LOCK_EN
    logic sw_lock_meta_q, sw_lock_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_lock_meta_q <= 1'b0;
            sw_lock_s_q    <= 1'b0;
        end else begin
            sw_lock_meta_q <= sw_lock;
            sw_lock_s_q    <= sw_lock_meta_q;
        end
    end

    assign sw_locked = sw_lock_s_q;
`else
    assign sw_locked = 1'b0;
`endif

    assign hw_req_ready = (state_q == S_IDLE) & hw_req_valid;
    assign sw_req_ready = (state_q == S_IDLE) & sw_req_valid & ~hw_req_valid & ~sw_locked;
    assign hw_accept    = hw_req_ready;
    assign sw_accept    = sw_req_ready;
    assign req_sel      = hw_accept ? hw_req_sel : sw_req_sel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        select_d = select_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hw_accept || sw_accept) begin
                    target_d = req_sel;
                    if (req_sel == select_q) begin
                        state_d = S_DONE_NOP;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end
                end
            end
            S_DONE_NOP: state_d = S_IDLE;
            S_CHECK: begin
                // Both clocks must run: the outgoing one has to release the mux.
                if (alive_s_q[0] && alive_s_q[1]) begin
                    select_d = target_q;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end else if (cnt_q == TC_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == TC_SETTLE) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == TC_HOLD) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            target_q     <= 1'b0;
            select_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            alive_meta_q <= 2'b00;
            alive_s_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            select_q     <= select_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            alive_meta_q <= {clk1_alive, clk0_alive};
            alive_s_q    <= alive_meta_q;
        end
    end

    assign select = select_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl; expected values are hand-derived edge by edge.
module tb_clk_switch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hw_req_valid = 1'b0, hw_req_sel = 1'b0, hw_req_ready;
    logic sw_req_valid = 1'b0, sw_req_sel = 1'b0, sw_req_ready;
    logic clk0_alive = 1'b0, clk1_alive = 1'b0;
    logic select, busy, done, err;
`ifdef CLKSW_SW_LOCK_EN
    logic sw_lock = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    clk_switch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hw_req_valid (hw_req_valid),
        .hw_req_sel   (hw_req_sel),
        .hw_req_ready (hw_req_ready),
        .sw_req_valid (sw_req_valid),
        .sw_req_sel   (sw_req_sel),
        .sw_req_ready (sw_req_ready),
`ifdef CLKSW_SW_LOCK_EN
        .sw_lock      (sw_lock),
`endif
        .clk0_alive   (clk0_alive),
        .clk1_alive   (clk1_alive),
        .select       (select),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic a0, input logic a1);
        rst_n = 1'b0;
        hw_req_valid = 1'b0; sw_req_valid = 1'b0;
        hw_req_sel = 1'b0;   sw_req_sel = 1'b0;
        clk0_alive = a0;     clk1_alive = a1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        logic seen;
        int   n;

        // reset values
        #1;
        check("rst_select", select, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // hw switch to clk1, full latency
        do_reset(1'b1, 1'b1);
        hw_req_valid = 1'b1; hw_req_sel = 1'b1;
        #1;
        check("hw_ready_idle", hw_req_ready, 1);
        tick();                                    // E0
        hw_req_valid = 1'b0;
        check("e0_select", select, 0);
        tick();                                    // E1
        check("e1_select", select, 1);
        check("e1_busy", busy, 1);
        for (int e = 2; e <= 26; e++) begin
            tick();
            if (e == 20) begin
                hw_req_valid = 1'b1; hw_req_sel = 1'b1;
            end
            if (e == 8)  check("e8_done", done, 0);
            if (e == 9)  check("e9_done", done, 1);
            if (e == 9)  check("e9_err", err, 0);
            if (e == 10) check("e10_done", done, 0);
            if (e == 25) begin
                check("e25_busy", busy, 1);
                check("e25_hw_ready", hw_req_ready, 0);
                check("e25_select", select, 1);
            end
            if (e == 26) begin
                check("e26_busy", busy, 0);
                check("e26_hw_ready", hw_req_ready, 1);
            end
        end
        // same-source hw request: no-op
        tick();
        hw_req_valid = 1'b0;
        check("nop_hw_done", done, 1);
        check("nop_hw_select", select, 1);
        tick();
        check("nop_hw_idle_busy", busy, 0);
        check("nop_hw_done_end", done, 0);

        // same-source sw request: no-op, no HOLD
        sw_req_valid = 1'b1; sw_req_sel = 1'b1;
        #1;
        check("nop_sw_ready", sw_req_ready, 1);
        tick();                                    // F0
        check("nop_sw_done", done, 1);
        check("nop_sw_ready_busy", sw_req_ready, 0);
        tick();                                    // F1
        check("nop_sw_done_end", done, 0);
        check("nop_sw_ready_again", sw_req_ready, 1);
        check("nop_sw_select", select, 1);
        sw_req_valid = 1'b0;

        // simultaneous hw/sw: hw wins, sw waits out HOLD
        do_reset(1'b1, 1'b1);
        hw_req_valid = 1'b1; hw_req_sel = 1'b1;
        sw_req_valid = 1'b1; sw_req_sel = 1'b0;
        #1;
        check("arb_hw_ready", hw_req_ready, 1);
        check("arb_sw_ready", sw_req_ready, 0);
        tick();                                    // E0
        hw_req_valid = 1'b0;
        #1;
        check("arb_sw_ready_busy", sw_req_ready, 0);
        tick();                                    // E1
        check("arb_select", select, 1);
        for (int e = 2; e <= 26; e++) begin
            tick();
            if (e == 25) check("arb_sw_ready_e25", sw_req_ready, 0);
            if (e == 26) check("arb_sw_ready_e26", sw_req_ready, 1);
        end
        tick();                                    // sw accepted, CHECK
        sw_req_valid = 1'b0;
        check("arb_sw_busy", busy, 1);
        tick();
        check("arb_sw_select", select, 0);

        // CHECK timeout with clk1 dead
        do_reset(1'b1, 1'b0);
        hw_req_valid = 1'b1; hw_req_sel = 1'b1;
        tick();                                    // E0
        hw_req_valid = 1'b0;
        seen = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            tick();
            if (err || done) seen = 1'b1;
        end
        check("to_no_early_pulse", seen, 0);
        tick();                                    // E64
        check("to_err", err, 1);
        check("to_done", done, 0);
        check("to_select", select, 0);
        check("to_busy", busy, 0);
        tick();
        check("to_err_end", err, 0);

        // reset during SETTLE
        do_reset(1'b1, 1'b1);
        hw_req_valid = 1'b1; hw_req_sel = 1'b1;
        tick();                                    // E0
        hw_req_valid = 1'b0;
        repeat (3) tick();
        check("mid_select_before", select, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_select", select, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        hw_req_valid = 1'b1; hw_req_sel = 1'b1;
        #1;
        check("mid_after_ready", hw_req_ready, 1);
        tick();
        hw_req_valid = 1'b0;
        check("mid_after_busy", busy, 1);

`ifdef CLKSW_SW_LOCK_EN
        // sw lock blocks software requests until released
        do_reset(1'b1, 1'b1);
        sw_lock = 1'b1;
        repeat (3) tick();
        sw_req_valid = 1'b1; sw_req_sel = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (sw_req_ready) seen = 1'b1;
            tick();
        end
        check("lock_ready_held", seen, 0);
        sw_lock = 1'b0;
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (sw_req_ready && n == 0) n = i;
        end
        check("lock_release_delay", (n >= 2 && n <= 3), 1);
        sw_req_valid = 1'b0;
`else
        n = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Single-clock sequencer that drives the `select` input of the two-clock glitch-free mux.
- Arbitrates clock-switch requests from a hardware requester (power manager) and a software requester (CSR).
- Before moving `select`, confirms both source clocks are alive. After moving it, waits out the mux handover and enforces a minimum dwell time.
- Runs on an always-on reference clock, separate from `clk0`/`clk1`.

Parameters:
- SETTLE_CYCLES, 8: cycles waited after `select` changes before `done` (covers the two-negedge handover).
- TIMEOUT_CYCLES, 64: cycles allowed in CHECK for both clocks to report alive.
- HOLD_CYCLES, 16: minimum cycles after `done` before the next request is accepted.
- CNT_W, 8: shared counter width; must hold max(SETTLE, TIMEOUT, HOLD).

Ports:
- clk  in  1  always-on reference clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- hw_req_valid  in  1  hardware switch request.
- hw_req_sel  in  1  requested source (0 = clk0, 1 = clk1).
- hw_req_ready  out  1  hardware request accepted this cycle.
- sw_req_valid  in  1  software switch request.
- sw_req_sel  in  1  requested source.
- sw_req_ready  out  1  software request accepted this cycle.
- clk0_alive  in  1  clock-monitor status for clk0; asynchronous, 2-FF synchronised internally.
- clk1_alive  in  1  same for clk1.
- select  out  1  registered mux select.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse when a switch completes (including no-op).
- err  out  1  one-cycle pulse on CHECK timeout.

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, alive synchronisers 0, select 0, busy 0, done 0, err 0.
- Readies are combinational:
  - hw_req_ready = IDLE & hw_req_valid.
  - sw_req_ready = IDLE & sw_req_valid & ~hw_req_valid.
- Arbitration: fixed priority, hw over sw. A requester holds valid and sel stable until ready. Accept = valid & ready; `target` is latched at the accept edge.
- States:
  - IDLE: on accept, if target == select, go to DONE_NOP; otherwise clear the counter and go to CHECK.
  - DONE_NOP: done = 1 for one cycle; select unchanged; go to IDLE. HOLD is skipped.
  - CHECK: each cycle test clk0_alive_s & clk1_alive_s. Both clocks are required because the outgoing clock must run to release the mux.
    - If both are 1: select <= target at this edge, clear the counter, go to SETTLE.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with alive still false: err = 1 for one cycle, select unchanged, go to IDLE.
  - SETTLE: count SETTLE_CYCLES cycles, then done = 1 for one cycle, clear the counter, go to HOLD.
  - HOLD: count HOLD_CYCLES cycles, then go to IDLE. No request is accepted.
- Latency, with accept at edge E0 and both clocks alive:
  - select toggles at E1.
  - done is high during the cycle starting at E1+SETTLE_CYCLES.
  - Both readies are next possible at E1+SETTLE_CYCLES+1+HOLD_CYCLES.
- done and err are never high in the same cycle.
- Request inputs are ignored while busy; requests are not queued.
- A request that arrives while busy is held by its requester and competes again on return to IDLE.
- alive input dropping during SETTLE or HOLD: no effect; the sequence completes.
- Mid-operation reset: immediate return to reset values, so select = 0 (clk0) asynchronously. The downstream mux is reset by the same rst_n.
- Counter never wraps; it saturates at its terminal compare.

Optional Feature:
- Macro CLKSW_SW_LOCK_EN adds input `sw_lock` (1 bit, asynchronous, 2-FF synchronised).
- With the macro: while sw_lock_s = 1, sw_req_ready is forced 0. A software request already accepted completes normally. hw requests are unaffected.
- Without the macro: the port is absent and sw requests are never locked.

Test Plan:
- Reset, then both alive=1 and hw_req_valid=1, sel=1 accepted at E0 -> select=1 at E1; done pulse at E9; busy 1 from E1 through E25; hw_req_ready possible again at E26.
- select=1, sw_req sel=1 -> one-cycle done pulse after accept, select stays 1, no HOLD (next accept two cycles later).
- hw and sw valid in the same IDLE cycle (hw sel=1, sw sel=0) -> hw_req_ready=1, sw_req_ready=0; select goes to 1; sw accepted only after HOLD.
- clk1_alive=0, request sel=1 -> after 64 CHECK cycles, err pulses once; select stays 0; no done; IDLE next cycle.
- rst_n asserted during SETTLE with select=1 -> select=0 and busy=0 immediately; after release a new request is accepted.
- CLKSW_SW_LOCK_EN defined, sw_lock=1, sw_req_valid=1 -> sw_req_ready stays 0 for 100 cycles. Deassert sw_lock -> accepted 2–3 cycles later.
